// File: rtl/ps2_key_decoder.sv
`timescale 1ns/1ps
// ps2_key_decoder
//   Receives PS/2 keyboard frames (scan code set 2) and reports the ASCII code
//   of the held key among B, D, E, F, R for the playback keyboard controller.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-low reset
//   ps2_clk      raw PS/2 clock pin (asynchronous)
//   ps2_data     raw PS/2 data pin (asynchronous)
//   pressed_key  ASCII of held key, 8'h00 when none
//   key_strobe   one-cycle pulse when pressed_key takes a new nonzero value
//   frame_error  one-cycle pulse on start/stop/parity/timeout error
//
// Parameter:
//   TIMEOUT_CYCLES  cycles without a PS/2 clock falling edge before a
//                   partial frame is aborted
//
// Build option:
//   PS2_PARITY_CHECK_EN  when defined, frames failing odd parity are dropped
//                        and flagged; otherwise the parity bit is ignored.
module ps2_key_decoder #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] pressed_key,
   output logic       key_strobe,
   output logic       frame_error
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t          state_q, state_d;
   logic            clk_s1, clk_s2, clk_prev;
   logic            dat_s1, dat_s2;
   logic            fall;
   logic [7:0]      shift_q;
   logic [2:0]      bit_cnt_q;
   logic            par_q;
   logic [CW-1:0]   to_cnt_q;
   logic            byte_done_q;
   logic            err_d, done_d;
   logic            frame_ok;
   logic            ext_flag, break_flag;
   logic [7:0]      code_ascii;

   // Two-stage synchronisers plus one extra stage on the clock for edge detect.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= ps2_data;
         dat_s2   <= dat_s1;
      end
   end

   assign fall = clk_prev & ~clk_s2;

`ifdef PS2_PARITY_CHECK_EN
   assign frame_ok = dat_s2 & (^{shift_q, par_q});
`else
   assign frame_ok = dat_s2;
`endif

   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (fall) begin
               if (!dat_s2) state_d = DATA;
               else         err_d   = 1'b1;
            end
         end
         DATA: begin
            if (fall && bit_cnt_q == 3'd7) state_d = PARITY;
         end
         PARITY: begin
            if (fall) state_d = STOP;
         end
         STOP: begin
            if (fall) begin
               state_d = IDLE;
               if (frame_ok) done_d = 1'b1;
               else          err_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A real edge takes priority over an expiring timeout in the same cycle.
      if (state_q != IDLE && !fall && to_cnt_q == TO_LAST) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         frame_error <= 1'b0;
         byte_done_q <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         par_q       <= 1'b0;
         to_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         frame_error <= err_d;
         byte_done_q <= done_d;
         if (fall && state_q == IDLE) bit_cnt_q <= '0;
         if (fall && state_q == DATA) begin
            shift_q[bit_cnt_q] <= dat_s2;
            bit_cnt_q          <= bit_cnt_q + 3'd1;
         end
         if (fall && state_q == PARITY) par_q <= dat_s2;
         if (fall || state_q == IDLE)   to_cnt_q <= '0;
         else if (to_cnt_q != TO_LAST)  to_cnt_q <= to_cnt_q + 1'b1;
      end
   end

   always_comb begin
      case (shift_q)
         8'h32:   code_ascii = 8'h42;
         8'h23:   code_ascii = 8'h44;
         8'h24:   code_ascii = 8'h45;
         8'h2B:   code_ascii = 8'h46;
         8'h2D:   code_ascii = 8'h52;
         default: code_ascii = 8'h00;
      endcase
   end

   // shift_q is stable while byte_done_q is high: the next data bit cannot
   // arrive until several cycles after the stop bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pressed_key <= '0;
         key_strobe  <= 1'b0;
         ext_flag    <= 1'b0;
         break_flag  <= 1'b0;
      end else begin
         key_strobe <= 1'b0;
         if (byte_done_q) begin
            if (shift_q == 8'hE0) begin
               ext_flag <= 1'b1;
            end else if (shift_q == 8'hF0) begin
               break_flag <= 1'b1;
            end else begin
               ext_flag   <= 1'b0;
               break_flag <= 1'b0;
               if (!ext_flag && code_ascii != 8'h00) begin
                  if (break_flag) begin
                     if (code_ascii == pressed_key) pressed_key <= '0;
                  end else if (code_ascii != pressed_key) begin
                     pressed_key <= code_ascii;
                     key_strobe  <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
`timescale 1ns/1ps
module tb_ps2_key_decoder;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] pressed_key;
   logic       key_strobe;
   logic       frame_error;

   ps2_key_decoder #(.TIMEOUT_CYCLES(100)) dut (
      .clock       (clock),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .pressed_key (pressed_key),
      .key_strobe  (key_strobe),
      .frame_error (frame_error)
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Pulse monitor, sampled away from the active edge.
   int          strobe_cnt = 0;
   int          err_cnt = 0;
   int          both_cnt = 0;
   int unsigned last_err_cyc = 0;
   always @(negedge clock) begin
      if (key_strobe) strobe_cnt++;
      if (frame_error) begin
         err_cnt++;
         last_err_cyc = cyc;
      end
      if (key_strobe && frame_error) both_cnt++;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int unsigned fall_cyc = 0;

   // Reference model: held key plus pending prefix flags.
   logic [7:0] m_key = 8'h00;
   bit         m_ext = 1'b0;
   bit         m_brk = 1'b0;
   int         m_strobes = 0;
   int         m_errs = 0;

   function automatic logic [7:0] ascii_of(input logic [7:0] code);
      case (code)
         8'h32:   return 8'h42;
         8'h23:   return 8'h44;
         8'h24:   return 8'h45;
         8'h2B:   return 8'h46;
         8'h2D:   return 8'h52;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] a;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         a = ascii_of(b);
         if (!m_ext && a != 8'h00) begin
            if (m_brk) begin
               if (a == m_key) m_key = 8'h00;
            end else if (a != m_key) begin
               m_key = a;
               m_strobes++;
            end
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic send_partial(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         repeat (4) @(posedge clock);
         #1 ps2_data = bits[i];
         repeat (4) @(posedge clock);
         #1 ps2_clk = 1'b0;
         fall_cyc = cyc;
         repeat (8) @(posedge clock);
         #1 ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic [10:0] bits;
      bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
      send_partial(bits, 11);
      repeat (8) @(posedge clock);
      #1;
   endtask

   task automatic send_code(input logic [7:0] d);
      send_frame(d, 1'b0, 1'b0);
      model_byte(d);
   endtask

   task automatic test_reset;
      logic [10:0] bits;
      repeat (3) @(posedge clock);
      #1;
      n_tests++;
      if (pressed_key !== 8'h00) begin
         n_fail++; $display("FAIL reset_key: got %h expected 00", pressed_key);
      end
      n_tests++;
      if (key_strobe !== 1'b0 || frame_error !== 1'b0) begin
         n_fail++; $display("FAIL reset_pulses: got %b%b expected 00", key_strobe, frame_error);
      end
      reset = 1'b1;
      repeat (4) @(posedge clock);
      send_code(8'h24);
      n_tests++;
      if (pressed_key !== m_key) begin
         n_fail++; $display("FAIL pre_reset_key: got %h expected %h", pressed_key, m_key);
      end
      bits = {1'b1, 1'b1, 8'h24, 1'b0};
      send_partial(bits, 4);
      #1 reset = 1'b0;
      #1;
      n_tests++;
      if (pressed_key !== 8'h00) begin
         n_fail++; $display("FAIL async_reset_key: got %h expected 00", pressed_key);
      end
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      m_key = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
      repeat (4) @(posedge clock);
      send_code(8'h24);
      n_tests++;
      if (pressed_key !== 8'h45 || strobe_cnt !== m_strobes) begin
         n_fail++; $display("FAIL post_reset_frame: got key %h strobes %0d expected 45 %0d",
                            pressed_key, strobe_cnt, m_strobes);
      end
      send_code(8'hF0); send_code(8'h24);
   endtask

   task automatic test_make_break;
      int s0;
      s0 = strobe_cnt;
      send_code(8'h24);
      n_tests++;
      if (pressed_key !== 8'h45 || strobe_cnt !== s0 + 1) begin
         n_fail++; $display("FAIL make_24: got key %h strobes %0d expected 45 %0d",
                            pressed_key, strobe_cnt - s0, 1);
      end
      send_code(8'h24);
      n_tests++;
      if (pressed_key !== 8'h45 || strobe_cnt !== s0 + 1) begin
         n_fail++; $display("FAIL typematic_24: got key %h strobes %0d expected 45 1",
                            pressed_key, strobe_cnt - s0);
      end
      send_code(8'hF0); send_code(8'h24);
      n_tests++;
      if (pressed_key !== 8'h00 || strobe_cnt !== s0 + 1) begin
         n_fail++; $display("FAIL break_24: got key %h strobes %0d expected 00 1",
                            pressed_key, strobe_cnt - s0);
      end
   endtask

   task automatic test_replace;
      int s0;
      s0 = strobe_cnt;
      send_code(8'h32);
      n_tests++;
      if (pressed_key !== 8'h42) begin
         n_fail++; $display("FAIL make_32: got %h expected 42", pressed_key);
      end
      send_code(8'h2D);
      n_tests++;
      if (pressed_key !== 8'h52 || strobe_cnt !== s0 + 2) begin
         n_fail++; $display("FAIL replace_2D: got key %h strobes %0d expected 52 2",
                            pressed_key, strobe_cnt - s0);
      end
      send_code(8'hF0); send_code(8'h32);
      n_tests++;
      if (pressed_key !== 8'h52) begin
         n_fail++; $display("FAIL break_other: got %h expected 52", pressed_key);
      end
      send_code(8'hF0); send_code(8'h2D);
      n_tests++;
      if (pressed_key !== 8'h00) begin
         n_fail++; $display("FAIL break_2D: got %h expected 00", pressed_key);
      end
   endtask

   task automatic test_parity;
      send_frame(8'h24, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
      m_errs++;
`else
      model_byte(8'h24);
`endif
      n_tests++;
      if (pressed_key !== m_key || err_cnt !== m_errs || strobe_cnt !== m_strobes) begin
         n_fail++; $display("FAIL bad_parity: got key %h errs %0d strobes %0d expected %h %0d %0d",
                            pressed_key, err_cnt, strobe_cnt, m_key, m_errs, m_strobes);
      end
      send_code(8'hF0); send_code(8'h24);
   endtask

   task automatic test_ignored;
      logic [10:0] bits;
      send_code(8'hE0); send_code(8'h24);
      n_tests++;
      if (pressed_key !== 8'h00 || strobe_cnt !== m_strobes) begin
         n_fail++; $display("FAIL ext_24: got key %h strobes %0d expected 00 %0d",
                            pressed_key, strobe_cnt, m_strobes);
      end
      send_code(8'h1C);
      n_tests++;
      if (pressed_key !== 8'h00 || strobe_cnt !== m_strobes) begin
         n_fail++; $display("FAIL unmapped_1C: got key %h expected 00", pressed_key);
      end
      send_frame(8'h2B, 1'b0, 1'b1);
      m_errs++;
      n_tests++;
      if (err_cnt !== m_errs || pressed_key !== 8'h00) begin
         n_fail++; $display("FAIL bad_stop: got errs %0d key %h expected %0d 00",
                            err_cnt, pressed_key, m_errs);
      end
      bits = '1;
      send_partial(bits, 1);
      repeat (8) @(posedge clock);
      m_errs++;
      n_tests++;
      if (err_cnt !== m_errs) begin
         n_fail++; $display("FAIL bad_start: got errs %0d expected %0d", err_cnt, m_errs);
      end
   endtask

   task automatic test_timeout;
      logic [10:0] bits;
      int unsigned delta;
      int          e0;
      bit          seen;
      bits = {1'b1, 1'b0, 8'h2B, 1'b0};
      e0 = err_cnt;
      send_partial(bits, 5);
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge clock);
         if (err_cnt != e0) seen = 1'b1;
      end
      repeat (4) @(posedge clock);
      delta = last_err_cyc - fall_cyc;
      n_tests++;
      if (!seen || err_cnt !== e0 + 1) begin
         n_fail++; $display("FAIL timeout_pulse: got %0d pulses expected 1", err_cnt - e0);
      end else if (delta < 100 || delta > 106) begin
         n_fail++; $display("FAIL timeout_delay: got %0d cycles expected 100..106", delta);
      end
      m_errs++;
      send_code(8'h2B);
      n_tests++;
      if (pressed_key !== 8'h46 || strobe_cnt !== m_strobes) begin
         n_fail++; $display("FAIL after_timeout_2B: got %h expected 46", pressed_key);
      end
      send_code(8'hF0); send_code(8'h2B);
   endtask

   task automatic test_random;
      logic [7:0] pool [9];
      logic [7:0] b;
      pool = '{8'h32, 8'h23, 8'h24, 8'h2B, 8'h2D, 8'h1C, 8'hF0, 8'hE0, 8'h1B};
      for (int i = 0; i < 40; i++) begin
         b = pool[$urandom_range(0, 8)];
         send_code(b);
         n_tests++;
         if (pressed_key !== m_key || strobe_cnt !== m_strobes || err_cnt !== m_errs) begin
            n_fail++;
            $display("FAIL random[%0d] byte %h: got key %h strobes %0d errs %0d expected %h %0d %0d",
                     i, b, pressed_key, strobe_cnt, err_cnt, m_key, m_strobes, m_errs);
         end
      end
   endtask

   task automatic test_exclusive;
      n_tests++;
      if (both_cnt !== 0) begin
         n_fail++; $display("FAIL strobe_error_overlap: got %0d cycles expected 0", both_cnt);
      end
   endtask

   initial begin
      test_reset;
      test_make_break;
      test_replace;
      test_parity;
      test_ignored;
      test_timeout;
      test_random;
      test_exclusive;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives PS/2 keyboard frames (scan code set 2) and produces the 8-bit ASCII `pressed_key` consumed by the playback keyboard controller.
- Recognised keys are B, D, E, F and R; `pressed_key` stays at the key's ASCII code while the key is held and returns to 8'h00 on release.
- Sits between the PS/2 connector pins and the playback control FSM, in the same clock domain as that FSM.

Parameters:
- TIMEOUT_CYCLES, 50000, clock cycles without a PS/2 clock falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to `clock`
- ps2_data  input  1  raw PS/2 data pin, asynchronous to `clock`
- pressed_key  output  8  ASCII of held key: 8'h42 B, 8'h44 D, 8'h45 E, 8'h46 F, 8'h52 R; 8'h00 when none
- key_strobe  output  1  one-cycle pulse when `pressed_key` changes to a new nonzero value
- frame_error  output  1  one-cycle pulse on a framing, parity or timeout error

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: pressed_key=8'h00, key_strobe=0, frame_error=0.
  - Internal: synchronisers=1, FSM=IDLE, break_flag=0, ext_flag=0, timeout counter=0.
  - Reset asserted mid-frame discards the partial frame.
- Input sync and edge detect:
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - A falling edge is detected on the synchronised clock (previous=1, current=0).
  - Data is sampled only on that detected edge.
- Frame FSM (11-bit frame, LSB first):
  - IDLE: on edge with data=0 (start bit) -> DATA, bit_cnt=0. On edge with data=1 -> stay in IDLE, pulse frame_error.
  - DATA: shift data in at bit index bit_cnt; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: on edge, if data=1 and odd parity holds over 9 bits -> byte complete. Otherwise frame_error pulse and the byte is discarded. Either way -> IDLE.
- Timeout:
  - Counter clears on every detected edge and counts while FSM != IDLE.
  - When it reaches TIMEOUT_CYCLES-1 -> IDLE and frame_error pulse. Counter saturates; no wrap.
- Byte interpretation (cycle after byte complete):
  - 8'hE0: ext_flag=1, no output change.
  - 8'hF0: break_flag=1, no output change.
  - Otherwise the byte is a code:
    - ext_flag=1: code ignored.
    - Make with a mapped code (32->B, 23->D, 24->E, 2B->F, 2D->R): if the ASCII differs from `pressed_key`, update `pressed_key` and pulse key_strobe in the same cycle. A typematic repeat of the held key produces no change and no strobe. A new key pressed while another is held replaces it.
    - Break of the currently held key: pressed_key=8'h00, no strobe.
    - Break of any other key: ignored.
    - Unmapped make: ignored.
  - break_flag and ext_flag clear after any non-prefix byte.
- Latency: `pressed_key` updates 2 cycles after the synchronised falling edge of the stop bit, i.e. 4 cycles after the raw pin edge.
- frame_error and key_strobe never assert in the same cycle.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: parity is checked as above; a failing frame is discarded and frame_error pulses.
- Undefined: the parity bit is sampled but ignored; only start/stop/timeout errors discard a frame.

Test Plan:
- Reset held low mid-frame, then released -> pressed_key=8'h00, FSM restarts, next valid frame for 24 decodes correctly.
- Frame 0x24 (data 00100100, parity 1, stop 1) -> pressed_key=8'h45, key_strobe one pulse; repeat 0x24 -> no strobe; F0,24 -> pressed_key=8'h00.
- Make 0x32 then make 0x2D without break -> pressed_key 8'h42 then 8'h52, two strobes; F0,32 -> pressed_key stays 8'h52.
- Frame 0x24 with parity bit 0 -> with PS2_PARITY_CHECK_EN: frame_error pulse, pressed_key unchanged; without it: pressed_key=8'h45.
- E0,24 -> no change; unmapped 0x1C -> no change; stop bit=0 -> frame_error pulse.
- Stop ps2_clk toggling after 4 data bits for TIMEOUT_CYCLES (set to 100) -> frame_error pulse at cycle 100, FSM IDLE, next frame 0x2B -> pressed_key=8'h46.
